figo_seq_monitor: RTL
=====================

# figo_seq_monitor

Downstream checker for the FIGO state machine. It samples the 3-bit registered state code (`detect`) every clock and checks each step against the FIGO transition table. It flags the first illegal step (sticky), counts state changes, measures dwell time in the current code, and pulses a stall indication when a code holds too long. Its outputs feed the vehicle-level status and diagnostic logic.

## Interface

Parameters:
- `DW`, default 8: width of the dwell counter.
- `STALL_LIMIT`, default 16: dwell value that triggers `stall`. Legal range is 1 to 2^DW-1.
- `CW`, default 16: width of the transition counter.

Ports (clock and reset first):
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `detect`, in, 3: state code from the FIGO FSM.
- `clear`, in, 1: clears the sticky fault and the stall history.
- `fault`, out, 1: sticky; set on the first illegal transition.
- `fault_prev`, out, 3: code before the offending step.
- `fault_curr`, out, 3: code after the offending step.
- `stall`, out, 1: one-cycle pulse when dwell reaches `STALL_LIMIT`.
- `dwell`, out, DW: consecutive cycles the code has been unchanged; saturates.
- `trans_count`, out, CW: number of code changes since reset; saturates.

## Operation

- `prev_q` (3 bits) holds the previously sampled code. It resets to 0, because the FSM also resets to code 0.
- Legal successors of each code (self-loop allowed only for 0, 2 and 6):
  - 0 goes to 0 or 1
  - 1 goes to 2 or 3
  - 2 goes to 2 or 3
  - 3 goes to 4 or 5
  - 4 goes to 5 or 6
  - 5 goes to 6 or 7
  - 6 goes to 6 or 7
  - 7 goes to 3 or 4
- Each cycle, the step `prev_q` to `detect` is looked up in the table:
  - Illegal step with `fault` = 0: set `fault`, and latch `fault_prev` = `prev_q` and `fault_curr` = `detect`.
  - Illegal step with `fault` = 1: ignore it. The first fault is preserved.
  - Holding in codes 1, 3, 4, 5 or 7 is an illegal step.
- When `detect` != `prev_q`:
  - `trans_count` increments by 1, saturating at 2^CW-1.
  - `dwell` loads 0.
- When `detect` == `prev_q`: `dwell` increments by 1, saturating at 2^DW-1.
- `stall` pulses for one cycle on the edge where `dwell` goes from `STALL_LIMIT`-1 to `STALL_LIMIT`. It does not re-fire during saturation. It fires again only after a code change and a fresh hold.
- `clear`:
  - Zeroes `fault`, `fault_prev` and `fault_curr`.
  - Does not affect `dwell` or `trans_count`.
  - If `clear` and an illegal step occur in the same cycle, the new fault is captured: `fault` = 1 with the new codes.
- Every update also sets `prev_q` = `detect`.

## Timing

- All outputs are registered, with latency 1: the effect of a `detect` value sampled at edge k is visible after edge k.
- Values after `reset`: `fault` = 0, `fault_prev` = 0, `fault_curr` = 0, `stall` = 0, `dwell` = 0, `trans_count` = 0, `prev_q` = 0.
- `reset` overrides `clear` and all detection logic.
- `reset` mid-sequence aborts any pending stall. The first post-reset sample of 0 counts as a legal hold (dwell 1).
- Boundaries:
  - `dwell` saturates without wrapping.
  - `trans_count` saturates without wrapping.
  - `stall` cannot assert in the same cycle as a code change.

## Structure

- Shared package `figo_pkg` holds:
  - Code constants `FIGO_S0` through `FIGO_S7`, each 3 bits.
  - An 8x8 constant `FIGO_LEGAL` (row = prev, column = next).
  - Defaults for `DW`, `CW` and `STALL_LIMIT`.
- Sub-module `figo_sat_cnt`, a parameterised-width saturating counter with increment and load-zero controls. It is instantiated twice: for `dwell` and for `trans_count`.
- The top level contains the legality lookup, the fault capture and the stall edge detect.

## Test plan

1. Reset, then drive `detect` = 0,1,3,5,7,4,6,6,7,3.
   - Required: `fault` stays 0, `stall` never pulses.
   - Required: `trans_count` = 8, `dwell` = 0 at the end.
2. Drive 0,1,5,0.
   - Required: `fault` = 1 one cycle after the 5 is sampled, with `fault_prev` = 1 and `fault_curr` = 5.
   - Required: the later 5→0 step does not change the latched codes.
3. Drive 0,1,3,3.
   - Required: `fault` = 1 with `fault_prev` = 3 and `fault_curr` = 3.
4. Hold 6 for 300 cycles with `STALL_LIMIT` = 16 and `DW` = 8.
   - Required: exactly one `stall` pulse, when `dwell` = 16.
   - Required: `dwell` saturates at 255 and `fault` stays 0.
5. Set `fault` via an illegal step, then assert `clear` in the same cycle as a new illegal 2→7 step.
   - Required: `fault` = 1, `fault_prev` = 2, `fault_curr` = 7.
   - Then `clear` alone: `fault` = 0.
6. Pulse `reset` mid-sequence with `trans_count` = 5 and `fault` = 1.
   - Required: all outputs read 0 in the next cycle; a following 0→1 step is legal.

Source files
------------

// File: rtl/figo_pkg.sv
// Shared constants for the FIGO state machine and its monitor: state codes,
// the legal-transition table and default monitor sizing.
package figo_pkg;

  localparam logic [2:0] FIGO_S0 = 3'd0;
  localparam logic [2:0] FIGO_S1 = 3'd1;
  localparam logic [2:0] FIGO_S2 = 3'd2;
  localparam logic [2:0] FIGO_S3 = 3'd3;
  localparam logic [2:0] FIGO_S4 = 3'd4;
  localparam logic [2:0] FIGO_S5 = 3'd5;
  localparam logic [2:0] FIGO_S6 = 3'd6;
  localparam logic [2:0] FIGO_S7 = 3'd7;

  localparam int unsigned FIGO_DW_DEFAULT          = 8;
  localparam int unsigned FIGO_CW_DEFAULT          = 16;
  localparam int unsigned FIGO_STALL_LIMIT_DEFAULT = 16;

  // Row index = previous code, bit index within the row = next code.
  localparam logic [7:0][7:0] FIGO_LEGAL = {
    8'b0001_1000,  // 7 -> 3, 4
    8'b1100_0000,  // 6 -> 6, 7
    8'b1100_0000,  // 5 -> 6, 7
    8'b0110_0000,  // 4 -> 5, 6
    8'b0011_0000,  // 3 -> 4, 5
    8'b0000_1100,  // 2 -> 2, 3
    8'b0000_1100,  // 1 -> 2, 3
    8'b0000_0011   // 0 -> 0, 1
  };

  function automatic logic figo_is_legal(input logic [2:0] prev, input logic [2:0] next);
    logic [7:0] row;
    row = FIGO_LEGAL[prev];
    return row[next];
  endfunction

endpackage

// File: rtl/figo_sat_cnt.sv
// Saturating up-counter with a load-zero control that takes priority over
// increment. Synchronous active-high reset.
module figo_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         zero_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] CntMax = '1;

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (zero_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/figo_seq_monitor.sv
// Checks each sampled FIGO state step against the legal-transition table,
// captures the first illegal step, and tracks dwell time and state changes.
module figo_seq_monitor
  import figo_pkg::*;
#(
  parameter int unsigned DW          = FIGO_DW_DEFAULT,
  parameter int unsigned STALL_LIMIT = FIGO_STALL_LIMIT_DEFAULT,
  parameter int unsigned CW          = FIGO_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    detect,
  input  logic          clear,
  output logic          fault,
  output logic [2:0]    fault_prev,
  output logic [2:0]    fault_curr,
  output logic          stall,
  output logic [DW-1:0] dwell,
  output logic [CW-1:0] trans_count
);

  // Dwell value one step before the stall threshold; stall fires on the
  // edge that takes dwell onto the threshold, so saturation cannot re-fire it.
  localparam logic [DW-1:0] StallPre = DW'(STALL_LIMIT - 1);

  logic [2:0] prev_d, prev_q;
  logic       fault_d, fault_q;
  logic [2:0] fault_prev_d, fault_prev_q;
  logic [2:0] fault_curr_d, fault_curr_q;
  logic       stall_d, stall_q;

  logic       code_change;
  logic       step_legal;
  logic [DW-1:0] dwell_cnt;
  logic [CW-1:0] trans_cnt;

  assign code_change = (detect != prev_q);
  assign step_legal  = figo_is_legal(prev_q, detect);

  always_comb begin
    prev_d       = detect;
    fault_d      = fault_q;
    fault_prev_d = fault_prev_q;
    fault_curr_d = fault_curr_q;
    // A new illegal step in the same cycle as clear wins over the clear.
    if (!step_legal && (!fault_q || clear)) begin
      fault_d      = 1'b1;
      fault_prev_d = prev_q;
      fault_curr_d = detect;
    end else if (clear) begin
      fault_d      = 1'b0;
      fault_prev_d = '0;
      fault_curr_d = '0;
    end
  end

  always_comb begin
    stall_d = !code_change && (dwell_cnt == StallPre);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= FIGO_S0;
      fault_q      <= 1'b0;
      fault_prev_q <= '0;
      fault_curr_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      fault_q      <= fault_d;
      fault_prev_q <= fault_prev_d;
      fault_curr_q <= fault_curr_d;
      stall_q      <= stall_d;
    end
  end

  figo_sat_cnt #(
    .W (DW)
  ) u_dwell_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (!code_change),
    .zero_i  (code_change),
    .count_o (dwell_cnt)
  );

  figo_sat_cnt #(
    .W (CW)
  ) u_trans_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (code_change),
    .zero_i  (1'b0),
    .count_o (trans_cnt)
  );

  assign fault       = fault_q;
  assign fault_prev  = fault_prev_q;
  assign fault_curr  = fault_curr_q;
  assign stall       = stall_q;
  assign dwell       = dwell_cnt;
  assign trans_count = trans_cnt;

endmodule
